// File: rtl/fft_butterfly_core_pkg.sv
// Shared constants and types for the radix-2 DIT butterfly stage.
// Samples are Q18.18 two's complement; complex fields are ordered (re, im).
package fft_butterfly_core_pkg;

  localparam int unsigned WORD_SIZE = 37;
  localparam int unsigned FRAC_BITS = 18;
  localparam int unsigned HALF_SIZE = FRAC_BITS;

  localparam logic signed [WORD_SIZE-1:0] ONE =
    {{(WORD_SIZE-FRAC_BITS-1){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};

  typedef struct packed {
    logic signed [WORD_SIZE-1:0] re;
    logic signed [WORD_SIZE-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fft_butterfly_core_if.sv
// Valid/ready bundle for the butterfly: input vector side and output vector side.
interface fft_butterfly_core_if #(
  parameter int unsigned WORD_SIZE = fft_butterfly_core_pkg::WORD_SIZE
);

  logic                        in_valid;
  logic                        in_ready;
  logic signed [WORD_SIZE-1:0] a_re;
  logic signed [WORD_SIZE-1:0] a_im;
  logic signed [WORD_SIZE-1:0] b_re;
  logic signed [WORD_SIZE-1:0] b_im;
  logic signed [WORD_SIZE-1:0] w_re;
  logic signed [WORD_SIZE-1:0] w_im;
  logic                        scale;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [WORD_SIZE-1:0] x0_re;
  logic signed [WORD_SIZE-1:0] x0_im;
  logic signed [WORD_SIZE-1:0] x1_re;
  logic signed [WORD_SIZE-1:0] x1_im;

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, w_re, w_im, scale, out_ready,
    input  in_ready, out_valid, x0_re, x0_im, x1_re, x1_im
  );

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, w_re, w_im, scale, out_ready,
    output in_ready, out_valid, x0_re, x0_im, x1_re, x1_im
  );

endinterface

// File: rtl/fft_butterfly_core_mult.sv
// Fixed-point multiplier with sign-magnitude semantics: |a|*|b| truncated
// toward zero to the input Q format, then the sign applied (zero is +0).
module double_sign_mult #(
  parameter int unsigned WORD_SIZE = fft_butterfly_core_pkg::WORD_SIZE,
  parameter int unsigned HALF_SIZE = fft_butterfly_core_pkg::HALF_SIZE
) (
  input  logic signed [WORD_SIZE-1:0] a,
  input  logic signed [WORD_SIZE-1:0] b,
  output logic signed [WORD_SIZE-1:0] p
);

  logic [WORD_SIZE-1:0]   mag_a;
  logic [WORD_SIZE-1:0]   mag_b;
  logic [WORD_SIZE-1:0]   mag_p;
  logic [2*WORD_SIZE-1:0] prod;
  logic                   unused_prod;

  always_comb begin
    mag_a = a[WORD_SIZE-1] ? (~a + 1'b1) : a;
    mag_b = b[WORD_SIZE-1] ? (~b + 1'b1) : b;
    prod  = {{WORD_SIZE{1'b0}}, mag_a} * {{WORD_SIZE{1'b0}}, mag_b};
    // Dropping the low fraction bits of the magnitude truncates toward zero.
    mag_p = prod[HALF_SIZE +: WORD_SIZE];
    p     = (a[WORD_SIZE-1] ^ b[WORD_SIZE-1]) ? -$signed(mag_p) : $signed(mag_p);
  end

  assign unused_prod = ^{prod[2*WORD_SIZE-1:HALF_SIZE+WORD_SIZE], prod[HALF_SIZE-1:0]};

endmodule

// File: rtl/fft_butterfly_core.sv
// Four-stage pipelined radix-2 DIT butterfly: X0 = A + W*B, X1 = A - W*B,
// optionally halved, with a single global stall driven by the output side.
module fft_butterfly_core import fft_butterfly_core_pkg::*; #(
  parameter int unsigned WORD_SIZE = fft_butterfly_core_pkg::WORD_SIZE,
  parameter int unsigned HALF_SIZE = FRAC_BITS
) (
  input  logic clk,
  input  logic rst_n,
  fft_butterfly_core_if.slave bus
);

  localparam int unsigned W = WORD_SIZE;

  logic en;

  logic                s1_valid, s1_scale;
  logic signed [W-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im, s1_w_re, s1_w_im;

  logic signed [W-1:0] m_rr, m_ii, m_ri, m_ir;

  logic                s2_valid, s2_scale;
  logic signed [W-1:0] s2_a_re, s2_a_im, s2_rr, s2_ii, s2_ri, s2_ir;

  logic                s3_valid, s3_scale;
  logic signed [W-1:0] s3_a_re, s3_a_im, s3_p_re, s3_p_im;

  logic                s4_valid;
  logic signed [W-1:0] s4_x0_re, s4_x0_im, s4_x1_re, s4_x1_im;
  logic signed [W-1:0] x0_re_d, x0_im_d, x1_re_d, x1_im_d;

  // Sum is formed one bit wider so the halving shift loses nothing; the
  // unscaled result simply wraps by keeping the low W bits.
  function automatic logic signed [W-1:0] bfly(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] p,
                                               input logic sub,
                                               input logic halve);
    logic signed [W:0] s;
    s = sub ? ({a[W-1], a} - {p[W-1], p}) : ({a[W-1], a} + {p[W-1], p});
    return halve ? s[W:1] : s[W-1:0];
  endfunction

  assign en           = !s4_valid || bus.out_ready;
  assign bus.in_ready = en;

  double_sign_mult #(.WORD_SIZE(W), .HALF_SIZE(HALF_SIZE)) u_mult_rr (.a(s1_b_re), .b(s1_w_re), .p(m_rr));
  double_sign_mult #(.WORD_SIZE(W), .HALF_SIZE(HALF_SIZE)) u_mult_ii (.a(s1_b_im), .b(s1_w_im), .p(m_ii));
  double_sign_mult #(.WORD_SIZE(W), .HALF_SIZE(HALF_SIZE)) u_mult_ri (.a(s1_b_re), .b(s1_w_im), .p(m_ri));
  double_sign_mult #(.WORD_SIZE(W), .HALF_SIZE(HALF_SIZE)) u_mult_ir (.a(s1_b_im), .b(s1_w_re), .p(m_ir));

  always_comb begin
    x0_re_d = bfly(s3_a_re, s3_p_re, 1'b0, s3_scale);
    x0_im_d = bfly(s3_a_im, s3_p_im, 1'b0, s3_scale);
    x1_re_d = bfly(s3_a_re, s3_p_re, 1'b1, s3_scale);
    x1_im_d = bfly(s3_a_im, s3_p_im, 1'b1, s3_scale);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_scale <= 1'b0;
      s1_a_re  <= '0;
      s1_a_im  <= '0;
      s1_b_re  <= '0;
      s1_b_im  <= '0;
      s1_w_re  <= '0;
      s1_w_im  <= '0;
      s2_valid <= 1'b0;
      s2_scale <= 1'b0;
      s2_a_re  <= '0;
      s2_a_im  <= '0;
      s2_rr    <= '0;
      s2_ii    <= '0;
      s2_ri    <= '0;
      s2_ir    <= '0;
      s3_valid <= 1'b0;
      s3_scale <= 1'b0;
      s3_a_re  <= '0;
      s3_a_im  <= '0;
      s3_p_re  <= '0;
      s3_p_im  <= '0;
      s4_valid <= 1'b0;
      s4_x0_re <= '0;
      s4_x0_im <= '0;
      s4_x1_re <= '0;
      s4_x1_im <= '0;
    end else if (en) begin
      s1_valid <= bus.in_valid;
      s1_scale <= bus.scale;
      s1_a_re  <= bus.a_re;
      s1_a_im  <= bus.a_im;
      s1_b_re  <= bus.b_re;
      s1_b_im  <= bus.b_im;
      s1_w_re  <= bus.w_re;
      s1_w_im  <= bus.w_im;

      s2_valid <= s1_valid;
      s2_scale <= s1_scale;
      s2_a_re  <= s1_a_re;
      s2_a_im  <= s1_a_im;
      s2_rr    <= m_rr;
      s2_ii    <= m_ii;
      s2_ri    <= m_ri;
      s2_ir    <= m_ir;

      s3_valid <= s2_valid;
      s3_scale <= s2_scale;
      s3_a_re  <= s2_a_re;
      s3_a_im  <= s2_a_im;
      s3_p_re  <= s2_rr - s2_ii;
      s3_p_im  <= s2_ri + s2_ir;

      s4_valid <= s3_valid;
      s4_x0_re <= x0_re_d;
      s4_x0_im <= x0_im_d;
      s4_x1_re <= x1_re_d;
      s4_x1_im <= x1_im_d;
    end
  end

  assign bus.out_valid = s4_valid;
  assign bus.x0_re     = s4_x0_re;
  assign bus.x0_im     = s4_x0_im;
  assign bus.x1_re     = s4_x1_re;
  assign bus.x1_im     = s4_x1_im;

endmodule

// File: tb/tb_fft_butterfly_core.sv
// Directed self-checking bench for fft_butterfly_core.
module tb_fft_butterfly_core;
  import fft_butterfly_core_pkg::*;

  localparam int unsigned W = WORD_SIZE;
  localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  typedef struct {
    cplx_t a, b, w;
    logic  sc;
    cplx_t e0, e1;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  fft_butterfly_core_if #(.WORD_SIZE(W)) bus ();

  fft_butterfly_core #(.WORD_SIZE(W), .HALF_SIZE(FRAC_BITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cplx_t cx(input logic signed [W-1:0] re, input logic signed [W-1:0] im);
    cx.re = re;
    cx.im = im;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input cplx_t a, input cplx_t b, input cplx_t w, input logic sc);
    bus.a_re  = a.re;
    bus.a_im  = a.im;
    bus.b_re  = b.re;
    bus.b_im  = b.im;
    bus.w_re  = w.re;
    bus.w_im  = w.im;
    bus.scale = sc;
  endtask

  task automatic idle_inputs();
    load(cx(0, 0), cx(0, 0), cx(0, 0), 1'b0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  // Push one vector into an empty pipeline and wait (bounded) for its result.
  task automatic send_one(input vec_t v, output int lat, output cplx_t x0, output cplx_t x1);
    load(v.a, v.b, v.w, v.sc);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 16) begin
      step();
      lat++;
    end
    x0 = cx(bus.x0_re, bus.x0_im);
    x1 = cx(bus.x1_re, bus.x1_im);
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if ({bus.x0_re, bus.x0_im, bus.x1_re, bus.x1_im} !== '0) begin
      errors++;
      $display("FAIL reset_x: got x0=(%0d,%0d) x1=(%0d,%0d) want all 0",
               bus.x0_re, bus.x0_im, bus.x1_re, bus.x1_im);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_identity();
    vec_t v;
    int lat;
    cplx_t x0, x1;
    v = '{a: cx(ONE, 0), b: cx(ONE, 0), w: cx(ONE, 0), sc: 1'b0,
          e0: cx(524288, 0), e1: cx(0, 0)};
    send_one(v, lat, x0, x1);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL identity_latency: got %0d want 4", lat);
    end
    checks++;
    if ({x0, x1} !== {v.e0, v.e1}) begin
      errors++;
      $display("FAIL identity_x: got x0=(%0d,%0d) x1=(%0d,%0d) want x0=(%0d,%0d) x1=(%0d,%0d)",
               x0.re, x0.im, x1.re, x1.im, v.e0.re, v.e0.im, v.e1.re, v.e1.im);
    end
  endtask

  task automatic test_rotation();
    vec_t v;
    int lat;
    cplx_t x0, x1;
    v = '{a: cx(0, 0), b: cx(131072, 65536), w: cx(0, -262144), sc: 1'b0,
          e0: cx(65536, -131072), e1: cx(-65536, 131072)};
    send_one(v, lat, x0, x1);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL rotation_latency: got %0d want 4", lat);
    end
    checks++;
    if ({x0, x1} !== {v.e0, v.e1}) begin
      errors++;
      $display("FAIL rotation_x: got x0=(%0d,%0d) x1=(%0d,%0d) want x0=(%0d,%0d) x1=(%0d,%0d)",
               x0.re, x0.im, x1.re, x1.im, v.e0.re, v.e0.im, v.e1.re, v.e1.im);
    end
  endtask

  task automatic test_scaling();
    vec_t v[3];
    int lat;
    cplx_t x0, x1;
    v[0] = '{a: cx(3*ONE, 0), b: cx(ONE, 0), w: cx(ONE, 0), sc: 1'b1,
             e0: cx(524288, 0), e1: cx(262144, 0)};
    v[1] = '{a: cx(-1, 0), b: cx(0, 0), w: cx(ONE, 0), sc: 1'b1,
             e0: cx(-1, 0), e1: cx(-1, 0)};
    v[2] = '{a: cx(3, -3), b: cx(0, 0), w: cx(0, 0), sc: 1'b1,
             e0: cx(1, -2), e1: cx(1, -2)};
    for (int i = 0; i < 3; i++) begin
      send_one(v[i], lat, x0, x1);
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL scaling_latency[%0d]: got %0d want 4", i, lat);
      end
      checks++;
      if ({x0, x1} !== {v[i].e0, v[i].e1}) begin
        errors++;
        $display("FAIL scaling_x[%0d]: got x0=(%0d,%0d) x1=(%0d,%0d) want x0=(%0d,%0d) x1=(%0d,%0d)",
                 i, x0.re, x0.im, x1.re, x1.im, v[i].e0.re, v[i].e0.im, v[i].e1.re, v[i].e1.im);
      end
    end
  endtask

  task automatic test_truncation();
    vec_t v[3];
    int lat;
    cplx_t x0, x1;
    v[0] = '{a: cx(5, 0), b: cx(-1, 0), w: cx(131072, 0), sc: 1'b0,
             e0: cx(5, 0), e1: cx(5, 0)};
    v[1] = '{a: cx(0, 0), b: cx(-3, 0), w: cx(131072, 0), sc: 1'b0,
             e0: cx(-1, 0), e1: cx(1, 0)};
    v[2] = '{a: cx(0, 0), b: cx(0, -3), w: cx(131072, 0), sc: 1'b0,
             e0: cx(0, -1), e1: cx(0, 1)};
    for (int i = 0; i < 3; i++) begin
      send_one(v[i], lat, x0, x1);
      checks++;
      if ({x0, x1} !== {v[i].e0, v[i].e1}) begin
        errors++;
        $display("FAIL truncation_x[%0d]: got x0=(%0d,%0d) x1=(%0d,%0d) want x0=(%0d,%0d) x1=(%0d,%0d)",
                 i, x0.re, x0.im, x1.re, x1.im, v[i].e0.re, v[i].e0.im, v[i].e1.re, v[i].e1.im);
      end
    end
  endtask

  task automatic test_wrap();
    vec_t v[4];
    int lat;
    cplx_t x0, x1;
    v[0] = '{a: cx(MAXV, 0), b: cx(ONE, 0), w: cx(1, 0), sc: 1'b0,
             e0: cx(MINV, 0), e1: cx(MAXV - 1, 0)};
    v[1] = '{a: cx(MAXV, 0), b: cx(ONE, 0), w: cx(1, 0), sc: 1'b1,
             e0: cx(37'sd34359738368, 0), e1: cx(37'sd34359738367, 0)};
    v[2] = '{a: cx(MINV, 0), b: cx(ONE, 0), w: cx(1, 0), sc: 1'b0,
             e0: cx(MINV + 1, 0), e1: cx(MAXV, 0)};
    v[3] = '{a: cx(MINV, 0), b: cx(ONE, 0), w: cx(1, 0), sc: 1'b1,
             e0: cx(-37'sd34359738368, 0), e1: cx(-37'sd34359738369, 0)};
    for (int i = 0; i < 4; i++) begin
      send_one(v[i], lat, x0, x1);
      checks++;
      if ({x0, x1} !== {v[i].e0, v[i].e1}) begin
        errors++;
        $display("FAIL wrap_x[%0d]: got x0=(%0d,%0d) x1=(%0d,%0d) want x0=(%0d,%0d) x1=(%0d,%0d)",
                 i, x0.re, x0.im, x1.re, x1.im, v[i].e0.re, v[i].e0.im, v[i].e1.re, v[i].e1.im);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[6];
    int sent, recv, stalls, extra;
    logic have_snap;
    cplx_t snap0, snap1, x0, x1;
    for (int i = 0; i < 6; i++) begin
      v[i].a  = cx(1000*i + 3, 7*i - 50);
      v[i].b  = cx(ONE*(i+1), 2*ONE);
      v[i].w  = cx(ONE, 0);
      v[i].sc = 1'b0;
      v[i].e0 = cx(1000*i + 3 + ONE*(i+1), 7*i - 50 + 2*ONE);
      v[i].e1 = cx(1000*i + 3 - ONE*(i+1), 7*i - 50 - 2*ONE);
    end
    sent = 0;
    recv = 0;
    stalls = 0;
    have_snap = 1'b0;
    for (int cyc = 0; cyc < 60 && recv < 6; cyc++) begin
      bus.out_ready = !(cyc >= 5 && cyc <= 7);
      if (sent < 6) begin
        load(v[sent].a, v[sent].b, v[sent].w, v[sent].sc);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      x0 = cx(bus.x0_re, bus.x0_im);
      x1 = cx(bus.x1_re, bus.x1_im);
      if (bus.out_valid && !bus.out_ready) begin
        stalls++;
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready cyc %0d: got %b want 0", cyc, bus.in_ready);
        end
        if (!have_snap) begin
          snap0 = x0;
          snap1 = x1;
          have_snap = 1'b1;
        end else begin
          checks++;
          if ({x0, x1} !== {snap0, snap1}) begin
            errors++;
            $display("FAIL stall_hold cyc %0d: got x0=(%0d,%0d) want x0=(%0d,%0d)",
                     cyc, x0.re, x0.im, snap0.re, snap0.im);
          end
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if ({x0, x1} !== {v[recv].e0, v[recv].e1}) begin
          errors++;
          $display("FAIL stream_x[%0d]: got x0=(%0d,%0d) x1=(%0d,%0d) want x0=(%0d,%0d) x1=(%0d,%0d)",
                   recv, x0.re, x0.im, x1.re, x1.im, v[recv].e0.re, v[recv].e0.im,
                   v[recv].e1.re, v[recv].e1.im);
        end
        recv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.out_valid) extra++;
      step();
    end
    checks++;
    if (recv !== 6) begin
      errors++;
      $display("FAIL stream_count: got %0d want 6", recv);
    end
    checks++;
    if (stalls !== 3) begin
      errors++;
      $display("FAIL stream_stall_cycles: got %0d want 3", stalls);
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL stream_duplicates: got %0d extra valid cycles want 0", extra);
    end
  endtask

  task automatic test_midflight_reset();
    vec_t nv;
    int lat, seen, first;
    cplx_t x0, x1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load(cx(11111*(i+1), 22222*(i+1)), cx(0, 0), cx(0, 0), 1'b0);
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if ({bus.x0_re, bus.x0_im, bus.x1_re, bus.x1_im} !== '0) begin
      errors++;
      $display("FAIL midreset_x: got x0=(%0d,%0d) x1=(%0d,%0d) want all 0",
               bus.x0_re, bus.x0_im, bus.x1_re, bus.x1_im);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_in_ready: got %b want 1", bus.in_ready);
    end
    nv = '{a: cx(424242, -99), b: cx(ONE, 0), w: cx(ONE, 0), sc: 1'b0,
           e0: cx(424242 + ONE, -99), e1: cx(424242 - ONE, -99)};
    load(nv.a, nv.b, nv.w, nv.sc);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    seen = 0;
    first = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.out_valid) begin
        seen++;
        if (first == 0) first = lat;
        x0 = cx(bus.x0_re, bus.x0_im);
        x1 = cx(bus.x1_re, bus.x1_im);
        checks++;
        if ({x0, x1} !== {nv.e0, nv.e1}) begin
          errors++;
          $display("FAIL midreset_result: got x0=(%0d,%0d) x1=(%0d,%0d) want x0=(%0d,%0d) x1=(%0d,%0d)",
                   x0.re, x0.im, x1.re, x1.im, nv.e0.re, nv.e0.im, nv.e1.re, nv.e1.im);
        end
      end
      step();
      lat++;
    end
    checks++;
    if (seen !== 1) begin
      errors++;
      $display("FAIL midreset_valid_count: got %0d want 1", seen);
    end
    checks++;
    if (first !== 4) begin
      errors++;
      $display("FAIL midreset_latency: got %0d want 4", first);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_identity();
    test_rotation();
    test_scaling();
    test_truncation();
    test_wrap();
    test_back_to_back();
    test_midflight_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
